rc4_engine: RTL and testbench
=============================

# rc4_engine

Parametrised RC4 decryption engine that runs the full RC4 flow from one start command: S-array initialisation, key scheduling (KSA), keystream generation (PRGA) and XOR decryption of a ciphertext ROM into an output RAM. It generalises the existing init/shuffle controller in three ways: a configurable key length, a configurable message length, and an optional plaintext plausibility check that aborts a run early on a wrong key. It sits below the key-search layer, which loads a key, pulses start and reads done/key_ok.

## Interface
- KEY_LENGTH, 3: key length in bytes, ≥1.
- MSG_LENGTH, 32: message length in bytes, 1..256.
- CHECK_EN, 1: when 1, abort on the first implausible plaintext byte.
- AW (localparam): max(1, $clog2(MSG_LENGTH)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only when busy=0.
- key  in  8*KEY_LENGTH  key; byte n = key[(KEY_LENGTH-1-n)*8 +: 8], so byte 0 is the MSB.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high from the end of a run until the next accepted start.
- key_ok  out  1  valid while done=1; 1 = whole message decrypted and passed the check.
- s_addr / s_wdata / s_we  out  8/8/1  S-RAM port (256x8, single port).
- s_rdata  in  8  S-RAM read data.
- rom_addr  out  AW  ciphertext ROM address.
- rom_rdata  in  8  ciphertext ROM read data.
- out_addr / out_wdata / out_we  out  AW/8/1  plaintext RAM write port.
- state_tap  out  4  encoded current state, for debug.

## Operation
- States:
  - IDLE
  - INIT
  - KSA_RD_I, KSA_LD_I, KSA_RD_J, KSA_LD_J, KSA_WR_I, KSA_WR_J
  - PRGA_RD_I, PRGA_LD_I, PRGA_RD_J, PRGA_LD_J, PRGA_WR_I, PRGA_WR_J, PRGA_RD_F, PRGA_LD_F, PRGA_WR_OUT
- The RAM and ROM read latency is one cycle. An address driven in an RD_* state is registered by the memory on that edge, and its data is captured by the engine in the following LD_* state.
- IDLE:
  - start=1 → INIT.
  - Clear done, key_ok, i, j and k.
  - The key is captured into a register at this same edge.
- INIT:
  - Write s[n]=n for n=0..255, one write per cycle (s_we=1).
  - After n=255 → KSA with i=0, j=0.
- KSA, 6 cycles per i:
  - KSA_LD_I: j ← j + s[i] + keybyte[i mod KEY_LENGTH].
  - KSA_WR_I: s[i] ← sj.
  - KSA_WR_J: s[j] ← si, then i++.
  - The key index comes from a separate counter that wraps at KEY_LENGTH-1; no divider.
  - After i=255 → PRGA with i=0, j=0, k=0.
- PRGA, 9 cycles per byte k:
  - The first state computes i ← i+1.
  - Read si, then j ← j+si.
  - Read sj, then swap (two writes).
  - PRGA_RD_F: drive s_addr=si+sj and rom_addr=k.
  - PRGA_LD_F: capture f and the ciphertext byte.
  - PRGA_WR_OUT: out[k] ← f ^ enc[k].
- Check and exit after each output write:
  - With CHECK_EN=1, a written byte is plausible only if it is 0x20 or in 0x61..0x7A.
  - An implausible byte is still written; then → IDLE with done=1, key_ok=0.
  - After k=MSG_LENGTH-1 with no failure → IDLE with done=1, key_ok=1.
- Arithmetic: all S-array index and j arithmetic is mod 256 (natural 8-bit wrap).
- Write strobes: at most one of s_we and out_we is high per cycle. Write strobes are low in all RD/LD states.
- start while busy=1 is ignored. start in the same cycle that done rises is ignored; done is registered first.
- The S-RAM is not restored by the engine; every run re-initialises it.

## Timing
- Reset values:
  - busy=0, done=0, key_ok=0.
  - s_we=0, out_we=0.
  - All address and data outputs 0.
  - state_tap=IDLE.
  - i, j, k and the key index are 0.
- Edge numbering: the edge that samples start is edge 0. busy=1 from edge 0.
- INIT writes occur after edges 0..255, KSA occupies edges 256..1791, and PRGA begins after edge 1792.
- Full-run latency: done=1 and busy=0 after edge 1792 + 9·MSG_LENGTH (2080 with defaults).
- Abort latency: an abort on byte k gives done after edge 1792 + 9·(k+1).
- Reset mid-run: all outputs return to their reset values immediately and asynchronously. The interrupted run is lost.

## Test plan
- INIT check: KEY_LENGTH=3, any key. The first 256 s_we cycles carry s_addr=n and s_wdata=n for n=0..255, and busy=1 throughout.
- Full decrypt, check off: KEY_LENGTH=3, key=24'h4B6579 ("Key"), CHECK_EN=0, MSG_LENGTH=9, ROM=BB F3 16 E8 D9 40 AF 0A D3 → out=50 6C 61 69 6E 74 65 78 74, key_ok=1, done at edge 1873.
- Early abort: same vector with CHECK_EN=1 → one out write only (out[0]=0x50), done at edge 1801, key_ok=0.
- Key length 4: KEY_LENGTH=4, key=32'h57696B69 ("Wiki"), MSG_LENGTH=5, CHECK_EN=1, ROM=10 21 BF 04 20 → out="pedia" (70 65 64 69 61), key_ok=1, done at edge 1837.
- Start while busy: pulse start during KSA and again during PRGA → no restart, and the result and timing are identical to the uninterrupted run.
- Reset mid-run: assert reset during PRGA → busy, done and the write strobes are 0 immediately. A new start then repeats the full-decrypt vector correctly.

Source files
------------

// File: rtl/rc4_engine.sv
// RC4 decryption engine: S-array init, key scheduling, keystream generation and
// XOR of a ciphertext ROM into a plaintext RAM, with optional early abort on implausible text.
module rc4_engine #(
    parameter int KEY_LENGTH = 3,
    parameter int MSG_LENGTH = 32,
    parameter int CHECK_EN   = 1,
    localparam int AW = (MSG_LENGTH > 1) ? $clog2(MSG_LENGTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] key,
    output logic                    busy,
    output logic                    done,
    output logic                    key_ok,
    output logic [7:0]              s_addr,
    output logic [7:0]              s_wdata,
    output logic                    s_we,
    input  logic [7:0]              s_rdata,
    output logic [AW-1:0]           rom_addr,
    input  logic [7:0]              rom_rdata,
    output logic [AW-1:0]           out_addr,
    output logic [7:0]              out_wdata,
    output logic                    out_we,
    output logic [3:0]              state_tap
);

    localparam int KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

    typedef enum logic [4:0] {
        ST_IDLE        = 5'd0,
        ST_INIT        = 5'd1,
        ST_KSA_RD_I    = 5'd2,
        ST_KSA_LD_I    = 5'd3,
        ST_KSA_RD_J    = 5'd4,
        ST_KSA_LD_J    = 5'd5,
        ST_KSA_WR_I    = 5'd6,
        ST_KSA_WR_J    = 5'd7,
        ST_PRGA_RD_I   = 5'd8,
        ST_PRGA_LD_I   = 5'd9,
        ST_PRGA_RD_J   = 5'd10,
        ST_PRGA_LD_J   = 5'd11,
        ST_PRGA_WR_I   = 5'd12,
        ST_PRGA_WR_J   = 5'd13,
        ST_PRGA_RD_F   = 5'd14,
        ST_PRGA_LD_F   = 5'd15,
        ST_PRGA_WR_OUT = 5'd16
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [7:0]              r_i;
    logic [7:0]              r_j;
    logic [AW-1:0]           r_k;
    logic [KW-1:0]           r_kidx;
    logic [7:0]              r_si;
    logic [7:0]              r_sj;
    logic [7:0]              r_f;
    logic [7:0]              r_enc;
    logic [8*KEY_LENGTH-1:0] r_key;
    logic                    r_done;
    logic                    r_key_ok;

    logic [7:0] w_key_byte;
    logic [7:0] w_plain;
    logic       w_plausible;
    logic       w_byte_ok;
    logic       w_last_i;
    logic       w_last_k;
    logic       w_last_kidx;

    always_comb begin
        w_key_byte = '0;
        for (int n = 0; n < KEY_LENGTH; n++) begin
            if (r_kidx == KW'(n)) w_key_byte = r_key[(KEY_LENGTH-1-n)*8 +: 8];
        end
    end

    assign w_plain     = r_f ^ r_enc;
    assign w_plausible = (w_plain == 8'h20) || ((w_plain >= 8'h61) && (w_plain <= 8'h7A));
    assign w_byte_ok   = (CHECK_EN == 0) || w_plausible;
    assign w_last_i    = (r_i == 8'hFF);
    assign w_last_k    = (r_k == AW'(MSG_LENGTH - 1));
    assign w_last_kidx = (r_kidx == KW'(KEY_LENGTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:        if (start) w_next = ST_INIT;
            ST_INIT:        if (w_last_i) w_next = ST_KSA_RD_I;
            ST_KSA_RD_I:    w_next = ST_KSA_LD_I;
            ST_KSA_LD_I:    w_next = ST_KSA_RD_J;
            ST_KSA_RD_J:    w_next = ST_KSA_LD_J;
            ST_KSA_LD_J:    w_next = ST_KSA_WR_I;
            ST_KSA_WR_I:    w_next = ST_KSA_WR_J;
            ST_KSA_WR_J:    w_next = w_last_i ? ST_PRGA_RD_I : ST_KSA_RD_I;
            ST_PRGA_RD_I:   w_next = ST_PRGA_LD_I;
            ST_PRGA_LD_I:   w_next = ST_PRGA_RD_J;
            ST_PRGA_RD_J:   w_next = ST_PRGA_LD_J;
            ST_PRGA_LD_J:   w_next = ST_PRGA_WR_I;
            ST_PRGA_WR_I:   w_next = ST_PRGA_WR_J;
            ST_PRGA_WR_J:   w_next = ST_PRGA_RD_F;
            ST_PRGA_RD_F:   w_next = ST_PRGA_LD_F;
            ST_PRGA_LD_F:   w_next = ST_PRGA_WR_OUT;
            ST_PRGA_WR_OUT: w_next = (!w_byte_ok || w_last_k) ? ST_IDLE : ST_PRGA_RD_I;
            default:        w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_kidx   <= '0;
            r_si     <= '0;
            r_sj     <= '0;
            r_f      <= '0;
            r_enc    <= '0;
            r_key    <= '0;
            r_done   <= 1'b0;
            r_key_ok <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key    <= key;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_kidx   <= '0;
                        r_done   <= 1'b0;
                        r_key_ok <= 1'b0;
                    end
                end
                ST_INIT:     r_i <= r_i + 8'd1;
                ST_KSA_LD_I: begin
                    r_si <= s_rdata;
                    r_j  <= r_j + s_rdata + w_key_byte;
                end
                ST_KSA_LD_J: r_sj <= s_rdata;
                ST_KSA_WR_J: begin
                    r_i    <= r_i + 8'd1;
                    r_kidx <= w_last_kidx ? '0 : r_kidx + 1'b1;
                    if (w_last_i) begin
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                ST_PRGA_RD_I: r_i <= r_i + 8'd1;
                ST_PRGA_LD_I: begin
                    r_si <= s_rdata;
                    r_j  <= r_j + s_rdata;
                end
                ST_PRGA_LD_J: r_sj <= s_rdata;
                ST_PRGA_LD_F: begin
                    r_f   <= s_rdata;
                    r_enc <= rom_rdata;
                end
                ST_PRGA_WR_OUT: begin
                    r_k <= r_k + 1'b1;
                    if (!w_byte_ok) begin
                        r_done   <= 1'b1;
                        r_key_ok <= 1'b0;
                    end else if (w_last_k) begin
                        r_done   <= 1'b1;
                        r_key_ok <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_addr    = '0;
        s_wdata   = '0;
        s_we      = 1'b0;
        rom_addr  = '0;
        out_addr  = '0;
        out_wdata = '0;
        out_we    = 1'b0;
        case (r_state)
            ST_INIT: begin
                s_addr  = r_i;
                s_wdata = r_i;
                s_we    = 1'b1;
            end
            ST_KSA_RD_I:  s_addr = r_i;
            ST_KSA_RD_J,
            ST_PRGA_RD_J: s_addr = r_j;
            ST_PRGA_RD_I: s_addr = r_i + 8'd1;
            ST_KSA_WR_I,
            ST_PRGA_WR_I: begin
                s_addr  = r_i;
                s_wdata = r_sj;
                s_we    = 1'b1;
            end
            ST_KSA_WR_J,
            ST_PRGA_WR_J: begin
                s_addr  = r_j;
                s_wdata = r_si;
                s_we    = 1'b1;
            end
            ST_PRGA_RD_F: begin
                s_addr   = r_si + r_sj;
                rom_addr = r_k;
            end
            ST_PRGA_WR_OUT: begin
                out_addr  = r_k;
                out_wdata = w_plain;
                out_we    = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign key_ok = r_key_ok;
    // 17 states in a 4-bit tap: PRGA_LD_F and PRGA_WR_OUT both read back as 4'hF
    assign state_tap = r_state[4] ? 4'hF : r_state[3:0];

endmodule

// File: tb/tb_rc4_engine.sv
// Bench for rc4_engine: three instances (check off, check on/abort, 4-byte key),
// each fed from a queue-based scoreboard checked by an independent monitor.
module tb_rc4_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int kl_of(input int g);  return (g == 2) ? 4 : 3; endfunction
    function automatic int msg_of(input int g); return (g == 2) ? 5 : 9; endfunction
    function automatic int chk_of(input int g); return (g == 0) ? 0 : 1; endfunction
    function automatic int nwr_of(input int g); return (g == 0) ? 9 : ((g == 1) ? 1 : 5); endfunction
    function automatic int ok_of(input int g);  return (g == 1) ? 0 : 1; endfunction
    function automatic int lat_of(input int g); return (g == 0) ? 1873 : ((g == 1) ? 1801 : 1837); endfunction
    function automatic logic [31:0] key_of(input int g);
        return (g == 2) ? 32'h57696B69 : 32'h004B6579;
    endfunction

    function automatic logic [7:0] rom_byte(input int g, input int n);
        logic [7:0] t [9];
        if (g == 2) t = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        else        t = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        return t[n];
    endfunction

    function automatic logic [7:0] exp_byte(input int g, input int n);
        logic [7:0] t [9];
        if (g == 2) t = '{8'h70, 8'h65, 8'h64, 8'h69, 8'h61, 8'h00, 8'h00, 8'h00, 8'h00};
        else        t = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        return t[n];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int KL  = kl_of(g);
        localparam int MSG = msg_of(g);
        localparam int CHK = chk_of(g);
        localparam int AW  = (MSG > 1) ? $clog2(MSG) : 1;

        logic            reset;
        logic            start;
        logic [8*KL-1:0] key;
        logic            busy, done, key_ok;
        logic [7:0]      s_addr, s_wdata, s_rdata;
        logic            s_we;
        logic [AW-1:0]   rom_addr, out_addr;
        logic [7:0]      rom_rdata, out_wdata;
        logic            out_we;
        logic [3:0]      state_tap;

        logic [7:0] s_mem [256];
        logic [7:0] rom [1<<AW];
        bit         fin = 1'b0;
        int         exp_q [$];
        int         res_q [$];
        int         pos = 0;

        rc4_engine #(
            .KEY_LENGTH(KL),
            .MSG_LENGTH(MSG),
            .CHECK_EN  (CHK)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start),
            .key      (key),
            .busy     (busy),
            .done     (done),
            .key_ok   (key_ok),
            .s_addr   (s_addr),
            .s_wdata  (s_wdata),
            .s_we     (s_we),
            .s_rdata  (s_rdata),
            .rom_addr (rom_addr),
            .rom_rdata(rom_rdata),
            .out_addr (out_addr),
            .out_wdata(out_wdata),
            .out_we   (out_we),
            .state_tap(state_tap)
        );

        always @(posedge clk) begin
            if (s_we) s_mem[s_addr] <= s_wdata;
            s_rdata   <= s_mem[s_addr];
            rom_rdata <= rom[rom_addr];
        end

        // Monitor: pops expectations whenever the DUT writes or finishes a run
        logic busy_q = 1'b0;
        logic done_q = 1'b0;
        int   init_n = 0;
        int   run_cyc = 0;
        int   last_ok = 0;

        always @(negedge clk) begin
            if (reset) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_key_ok", int'(key_ok), 0);
                chk("rst_strobes", int'({s_we, out_we}), 0);
                chk("rst_state_tap", int'(state_tap), 0);
                chk("rst_data_out", int'({s_addr, s_wdata, out_wdata}), 0);
                chk("rst_addr_out", int'({rom_addr, out_addr}), 0);
                exp_q.delete();
                res_q.delete();
                busy_q  = 1'b0;
                done_q  = 1'b0;
                init_n  = 0;
                run_cyc = 0;
            end else begin
                if (busy && !busy_q) begin
                    init_n  = 0;
                    run_cyc = 0;
                end
                if (busy) begin
                    run_cyc++;
                    if (run_cyc == lat_of(g) + 50) chk("run_timeout", run_cyc, lat_of(g));
                end
                if (s_we || out_we) chk("strobe_excl", int'(s_we & out_we), 0);
                if (s_we && init_n < 256) begin
                    chk("init_addr", int'(s_addr), init_n);
                    chk("init_data", int'(s_wdata), init_n);
                    chk("init_busy", int'(busy), 1);
                    init_n++;
                end
                if (out_we) begin
                    chk("out_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        int e;
                        e = exp_q.pop_front();
                        chk("out_addr", int'(out_addr), e / 256);
                        chk("out_data", int'(out_wdata), e % 256);
                    end
                end
                if (done && !done_q) begin
                    chk("busy_at_done", int'(busy), 0);
                    chk("out_all_written", exp_q.size(), 0);
                    chk("res_pending", int'(res_q.size() > 0), 1);
                    if (res_q.size() > 0) begin
                        int r;
                        r = res_q.pop_front();
                        chk("done_latency", run_cyc, r / 2);
                        chk("key_ok", int'(key_ok), r % 2);
                    end
                    last_ok = int'(key_ok);
                end else if (done && done_q) begin
                    chk("key_ok_hold", int'(key_ok), last_ok);
                end
                busy_q = busy;
                done_q = done;
            end
        end

        task automatic advance(input int e);
            while (pos < e) begin
                @(negedge clk);
                pos++;
            end
        endtask

        task automatic pulse_at(input int e);
            advance(e - 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            pos = e;
        endtask

        task automatic run(input bit pulses, input bit rst_mid);
            int w;
            for (int n = 0; n < nwr_of(g); n++) exp_q.push_back(n * 256 + int'(exp_byte(g, n)));
            res_q.push_back(lat_of(g) * 2 + ok_of(g));
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            pos = 0;
            if (pulses) begin
                pulse_at(500);
                pulse_at(1795);
            end
            if (rst_mid) begin
                advance(1796);
                @(posedge clk);
                #1 reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end else begin
                w = 0;
                while (!done && w < 2500) begin
                    @(negedge clk);
                    w++;
                end
            end
            repeat (4) @(negedge clk);
        endtask

        initial begin : stim
            logic [31:0] key_all;
            key_all = key_of(g);
            key   = key_all[8*KL-1:0];
            reset = 1'b1;
            start = 1'b0;
            for (int n = 0; n < (1 << AW); n++) rom[n] = (n < MSG) ? rom_byte(g, n) : 8'h00;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (2) @(negedge clk);
            run(1'b0, 1'b0);
            run(1'b1, 1'b0);
            run(1'b0, 1'b1);
            run(1'b0, 1'b0);
            fin = 1'b1;
        end
    end

    initial begin : finisher
        int w;
        w = 0;
        while (!(gen_dut[0].fin && gen_dut[1].fin && gen_dut[2].fin) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20000) begin
            $display("FAIL global_timeout: waited %0d cycles, limit 20000", w);
            $fatal(1, "bench did not complete");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
